multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle RV32I core. It sequences fetch, decode, execute, memory and write-back over the shared PC, IR, ALU, register file and single memory port, and drives their enables and mux selects from the current state and opcode. It also counts retired instructions and halts the core on illegal opcodes, ECALL/EBREAK or a memory timeout.

Parameters:
CNT_W, 32, width of retired-instruction counter
TIMEOUT, 255, max cycles mem_req may wait for mem_ready before bus error (>=1)

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset, sampled on rising clk
op  in  7  IR[6:0] opcode (valid from DECODE on)
br_taken  in  1  branch comparator result for current IR
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request
mem_we  out  1  store request (only with mem_req)
addr_sel  out  1  0=PC (instruction), 1=ALU result (data)
ir_we  out  1  latch memory read data into IR
pc_we  out  1  update PC
pc_src  out  2  0=PC+4, 1=PC+imm (JAL/branch), 2=(rs1+imm)&~1 (JALR)
alu_a_sel  out  2  0=rs1, 1=PC, 2=zero (LUI)
alu_b_sel  out  1  0=rs2, 1=imm
reg_we  out  1  register-file write
wb_sel  out  2  0=ALU, 1=load data, 2=PC+4
halted  out  1  core stopped (sticky)
cause  out  2  0=none, 1=illegal opcode, 2=ECALL/EBREAK, 3=bus timeout
retired  out  CNT_W  instructions retired since reset

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset (rst_n low at a clk edge, any state, including mid memory request): next state FETCH; retired=0, halted=0, cause=0, watchdog cleared. Every output deasserts for the whole cycle after the reset edge until FETCH drives it. Selects are 0.
- FETCH: mem_req=1, mem_we=0, addr_sel=0. Hold until mem_ready=1. On that cycle ir_we=1, then go to DECODE.
- DECODE: one cycle, no enables. Register file and immediate settle. Go to EXEC.
- EXEC, by op:
  - 0110011 OP / 0010011 OP-IMM: alu_b_sel=op[5]?0:1, then WB.
  - 0110111 LUI: a_sel=2, b=imm, then WB.
  - 0010111 AUIPC: a_sel=1, b=imm, then WB.
  - 1101111 JAL: reg_we=1, wb_sel=2, pc_we=1, pc_src=1, then FETCH.
  - 1100111 JALR: same as JAL with pc_src=2.
  - 1100011 BRANCH: pc_we=1, pc_src = br_taken?1:0 (Mealy on br_taken), then FETCH.
  - 0000011 LOAD / 0100011 STORE: a=rs1, b=imm, then MEM.
  - 0001111 FENCE: pc_we=1, pc_src=0, then FETCH.
  - 1110011 SYSTEM: cause=2, then HALT.
  - Any other opcode: cause=1, then HALT.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for STORE. Hold until mem_ready.
  - STORE: on ready, pc_we=1, pc_src=0, then FETCH.
  - LOAD: on ready, go to WB.
- WB: reg_we=1, wb_sel = LOAD?1:0, pc_we=1, pc_src=0, then FETCH.
- Handshake: mem_req, mem_we and addr_sel stay stable while waiting. mem_ready is ignored when mem_req=0. A request completes in the same cycle mem_ready is seen (zero-wait memory gives FETCH one cycle).
- Watchdog: counts consecutive cycles with mem_req=1 and mem_ready=0. Clears on completion.
  - Reaching TIMEOUT: cause=3, then HALT. The request drops the next cycle and no enables fire.
  - mem_ready on the same cycle as the count reaching TIMEOUT: completion wins.
- HALT: halted=1, all enables 0, cause frozen. Exit only by reset.
- pc_we fires exactly once per instruction. retired increments on each pc_we and wraps modulo 2^CNT_W. Halting instructions do not retire.
- Latency with zero-wait memory: ALU/LUI/AUIPC 4 cycles, branch/JAL/JALR/FENCE 3, store 4, load 5.

Decomposition:
- Shared header rv32i_defs.vh holds:
  - opcode constants (also used by the immediate generator)
  - pc_src, wb_sel and alu_a_sel encodings
  - cause codes
  - state encodings
- One sub-module: ctrl_watchdog (TIMEOUT counter; inputs busy/ready, output expired).

Test Plan:
- Reset then ADDI (op=0010011), mem_ready=1 always -> FETCH/DECODE/EXEC/WB in 4 cycles; reg_we=1 with alu_b_sel=1, wb_sel=0 in WB; retired=1.
- LW with mem_ready delayed 3 cycles in MEM -> mem_req, addr_sel=1 stable for 4 cycles; WB with wb_sel=1; retired increments once.
- BEQ with br_taken=1, then again with br_taken=0 -> pc_src=1, then pc_src=0; pc_we=1 in EXEC; back to FETCH next cycle.
- op=0000000 -> HALT, cause=1, halted=1; mem_req stays 0 for 10 further cycles; retired unchanged.
- TIMEOUT=4, mem_ready held 0 in FETCH -> after 4 waiting cycles cause=3, HALT; also mem_ready=1 exactly on 4th cycle -> normal DECODE.
- rst_n low during MEM of SW with mem_ready=0 -> FETCH next cycle, mem_we never pulses with mem_ready, retired=0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path.
// Holds the opcode constants (also used by the immediate generator), the
// pc_src / wb_sel / alu_a_sel / alu_b_sel encodings, the halt cause codes,
// the control FSM state encoding and the ALU operand-select decode helper.
package multicycle_ctrl_pkg;

    // RV32I major opcodes (IR[6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Next-PC source
    localparam logic [1:0] PC_SRC_SEQ  = 2'd0;  // PC + 4
    localparam logic [1:0] PC_SRC_REL  = 2'd1;  // PC + imm
    localparam logic [1:0] PC_SRC_JALR = 2'd2;  // (rs1 + imm) & ~1

    // Register-file write-back source
    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;

    // ALU operand selects
    localparam logic [1:0] ALU_A_RS1  = 2'd0;
    localparam logic [1:0] ALU_A_PC   = 2'd1;
    localparam logic [1:0] ALU_A_ZERO = 2'd2;
    localparam logic       ALU_B_RS2  = 1'b0;
    localparam logic       ALU_B_IMM  = 1'b1;

    // Halt causes
    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_SYSTEM  = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic [1:0] a_sel;
        logic       b_sel;
    } alu_sel_t;

    // ALU operand selection for an opcode; held from EXEC through MEM/WB so
    // the ALU result (data address or write-back value) stays valid.
    function automatic alu_sel_t alu_sel_for(input logic [6:0] opc);
        alu_sel_t s;
        s.a_sel = ALU_A_RS1;
        s.b_sel = ALU_B_RS2;
        case (opc)
            OPC_OP, OPC_OP_IMM: s.b_sel = opc[5] ? ALU_B_RS2 : ALU_B_IMM;
            OPC_LUI: begin
                s.a_sel = ALU_A_ZERO;
                s.b_sel = ALU_B_IMM;
            end
            OPC_AUIPC: begin
                s.a_sel = ALU_A_PC;
                s.b_sel = ALU_B_IMM;
            end
            OPC_JALR, OPC_LOAD, OPC_STORE: s.b_sel = ALU_B_IMM;
            default: s.b_sel = ALU_B_RS2;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ctrl_watchdog.sv
// Memory-request watchdog.
// Counts consecutive cycles in which a request is outstanding (i_busy) but
// not completed (i_ready). o_expired rises combinationally on the TIMEOUT-th
// such cycle; a completion in that same cycle suppresses it.
// Ports: clk, rst_n (sync, active-low), i_busy, i_ready, o_expired.
module ctrl_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_busy,
    input  logic i_ready,
    output logic o_expired
);

    // Count only needs to reach TIMEOUT-1: the last waiting cycle is detected
    // combinationally rather than stored.
    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] r_cnt;
    logic          w_waiting;

    assign w_waiting = i_busy & ~i_ready;
    assign o_expired = w_waiting & (r_cnt == CW'(TIMEOUT - 1));

    // Wait-cycle counter, cleared on completion or when no request is pending
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_waiting) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= '0;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) over the shared
// datapath and single memory port, counts retired instructions and halts
// on illegal opcodes, SYSTEM (ECALL/EBREAK) or a memory timeout.
// Ports: clk, rst_n (sync, active-low); op, br_taken, mem_ready in;
// mem_req/mem_we/addr_sel, ir_we, pc_we/pc_src, alu_a_sel/alu_b_sel,
// reg_we/wb_sel, halted/cause, retired out.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic             br_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_a_sel,
    output logic             alu_b_sel,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             halted,
    output logic [1:0]       cause,
    output logic [CNT_W-1:0] retired
);

    state_t           r_state;
    logic             r_halted;
    logic [1:0]       r_cause;
    logic [CNT_W-1:0] r_retired;
    logic             w_expired;
    alu_sel_t         w_alu;

    assign w_alu   = alu_sel_for(op);
    assign halted  = r_halted;
    assign cause   = r_cause;
    assign retired = r_retired;

    ctrl_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_busy    (mem_req),
        .i_ready   (mem_ready),
        .o_expired (w_expired)
    );

    // Datapath enables and selects; completion strobes (ir_we, store pc_we)
    // and the branch pc_src follow the inputs within the same cycle.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_SRC_SEQ;
        alu_a_sel = ALU_A_RS1;
        alu_b_sel = ALU_B_RS2;
        reg_we    = 1'b0;
        wb_sel    = WB_SEL_ALU;
        case (r_state)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            ST_EXEC: begin
                alu_a_sel = w_alu.a_sel;
                alu_b_sel = w_alu.b_sel;
                case (op)
                    OPC_JAL, OPC_JALR: begin
                        reg_we = 1'b1;
                        wb_sel = WB_SEL_PC4;
                        pc_we  = 1'b1;
                        pc_src = (op == OPC_JALR) ? PC_SRC_JALR : PC_SRC_REL;
                    end
                    OPC_BRANCH: begin
                        pc_we  = 1'b1;
                        pc_src = br_taken ? PC_SRC_REL : PC_SRC_SEQ;
                    end
                    OPC_FENCE: pc_we = 1'b1;
                    default:   pc_we = 1'b0;
                endcase
            end
            ST_MEM: begin
                alu_a_sel = w_alu.a_sel;
                alu_b_sel = w_alu.b_sel;
                mem_req   = 1'b1;
                addr_sel  = 1'b1;
                mem_we    = (op == OPC_STORE);
                // A store retires on its memory completion; a load goes on to WB
                if (op == OPC_STORE) begin
                    pc_we = mem_ready;
                end else begin
                    pc_we = 1'b0;
                end
            end
            ST_WB: begin
                alu_a_sel = w_alu.a_sel;
                alu_b_sel = w_alu.b_sel;
                reg_we    = 1'b1;
                wb_sel    = (op == OPC_LOAD) ? WB_SEL_LOAD : WB_SEL_ALU;
                pc_we     = 1'b1;
            end
            default: pc_we = 1'b0;  // DECODE and HALT drive nothing
        endcase
    end

    // State sequencing, halt cause capture and retired-instruction counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_FETCH;
            r_halted  <= 1'b0;
            r_cause   <= CAUSE_NONE;
            r_retired <= '0;
        end else begin
            if (pc_we) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            case (r_state)
                ST_FETCH: begin
                    if (mem_ready) begin
                        r_state <= ST_DECODE;
                    end else if (w_expired) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                        r_cause  <= CAUSE_TIMEOUT;
                    end
                end
                ST_DECODE: r_state <= ST_EXEC;
                ST_EXEC: begin
                    case (op)
                        OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC:
                            r_state <= ST_WB;
                        OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_FENCE:
                            r_state <= ST_FETCH;
                        OPC_LOAD, OPC_STORE:
                            r_state <= ST_MEM;
                        OPC_SYSTEM: begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                            r_cause  <= CAUSE_SYSTEM;
                        end
                        default: begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                            r_cause  <= CAUSE_ILLEGAL;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        r_state <= (op == OPC_STORE) ? ST_FETCH : ST_WB;
                    end else if (w_expired) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                        r_cause  <= CAUSE_TIMEOUT;
                    end
                end
                ST_WB:   r_state <= ST_FETCH;
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver pushes the hand-derived
// expected output vector for every cycle it drives; a negedge monitor pops
// and compares it against the DUT outputs.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned TIMEOUT = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [6:0]       op = 7'd0;
    logic             br_taken = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_req, mem_we, addr_sel, ir_we, pc_we;
    logic [1:0]       pc_src, alu_a_sel, wb_sel, cause;
    logic             alu_b_sel, reg_we, halted;
    logic [CNT_W-1:0] retired;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .br_taken(br_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .reg_we(reg_we),
        .wb_sel(wb_sel), .halted(halted), .cause(cause), .retired(retired)
    );

    // Vector layout: [15]req [14]we [13]addr [12]ir_we [11]pc_we [10:9]pc_src
    // [8:7]alu_a [6]alu_b [5]reg_we [4:3]wb_sel [2]halted [1:0]cause
    typedef struct {
        logic [15:0]      v;
        logic [15:0]      m;
        logic [CNT_W-1:0] ret;
        string            name;
    } exp_t;

    exp_t             sb_q[$];
    int               n_pass = 0;
    int               n_total = 0;
    logic [CNT_W-1:0] m_retired = '0;
    logic             m_halted = 1'b0;
    logic [1:0]       m_cause = 2'd0;
    exp_t             mon_e;
    logic [15:0]      mon_act;

    function automatic logic [15:0] ov(input logic req, input logic we, input logic adr,
                                       input logic irw, input logic pcw, input logic [1:0] psrc,
                                       input logic [1:0] a, input logic b, input logic rwe,
                                       input logic [1:0] wb);
        return {req, we, adr, irw, pcw, psrc, a, b, rwe, wb, 3'b000};
    endfunction

    // Care mask: pc_src, ALU selects and wb_sel are checked only where defined
    function automatic logic [15:0] cm(input logic psrc_c, input logic alu_c, input logic wb_c);
        logic [15:0] m;
        m = 16'hFFFF;
        if (!psrc_c) m[10:9] = 2'b00;
        if (!alu_c)  m[8:6]  = 3'b000;
        if (!wb_c)   m[4:3]  = 2'b00;
        return m;
    endfunction

    task automatic drive(input string name, input logic [6:0] opc, input logic rdy,
                         input logic brt, input logic [15:0] v, input logic [15:0] m);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        op        = opc;
        mem_ready = rdy;
        br_taken  = brt;
        e.v    = v | {13'd0, m_halted, m_cause};
        e.m    = m;
        e.ret  = m_retired;
        e.name = name;
        sb_q.push_back(e);
        if (v[11]) m_retired = m_retired + 32'd1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        m_retired = '0;
        m_halted  = 1'b0;
        m_cause   = 2'd0;
    endtask

    task automatic fetch(input logic [6:0] opc, input int waits);
        for (int i = 0; i < waits; i++)
            drive("fetch_wait", opc, 1'b0, 1'b0, ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0), cm(1'b0, 1'b0, 1'b0));
        drive("fetch", opc, 1'b1, 1'b0, ov(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0), cm(1'b0, 1'b0, 1'b0));
        drive("decode", opc, 1'b1, 1'b0, 16'h0000, cm(1'b0, 1'b0, 1'b0));
    endtask

    task automatic alu_instr(input string name, input logic [6:0] opc, input logic [1:0] a,
                             input logic b, input int fw);
        fetch(opc, fw);
        drive({name, "_exec"}, opc, 1'b1, 1'b0, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, a, b, 1'b0, 2'd0), cm(1'b0, 1'b1, 1'b0));
        drive({name, "_wb"}, opc, 1'b1, 1'b0, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, PC_SRC_SEQ, a, b, 1'b1, WB_SEL_ALU), cm(1'b1, 1'b1, 1'b1));
    endtask

    task automatic jump(input string name, input logic [6:0] opc, input logic [1:0] psrc);
        fetch(opc, 0);
        drive({name, "_exec"}, opc, 1'b1, 1'b0, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, psrc, 2'd0, 1'b0, 1'b1, WB_SEL_PC4), cm(1'b1, 1'b0, 1'b1));
    endtask

    task automatic branch(input string name, input logic brt);
        fetch(OPC_BRANCH, 0);
        drive(name, OPC_BRANCH, 1'b0, brt, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, brt ? PC_SRC_REL : PC_SRC_SEQ, 2'd0, 1'b0, 1'b0, 2'd0), cm(1'b1, 1'b0, 1'b0));
    endtask

    task automatic fence();
        fetch(OPC_FENCE, 0);
        drive("fence_exec", OPC_FENCE, 1'b1, 1'b0, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, PC_SRC_SEQ, 2'd0, 1'b0, 1'b0, 2'd0), cm(1'b1, 1'b0, 1'b0));
    endtask

    // Load/store up to the memory phase; 'waits' cycles with mem_ready low
    task automatic mem_head(input logic [6:0] opc, input int waits);
        logic st;
        st = (opc == OPC_STORE);
        fetch(opc, 0);
        drive("ls_exec", opc, 1'b1, 1'b0, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, ALU_A_RS1, ALU_B_IMM, 1'b0, 2'd0), cm(1'b0, 1'b1, 1'b0));
        for (int i = 0; i < waits; i++)
            drive("mem_wait", opc, 1'b0, 1'b0, ov(1'b1, st, 1'b1, 1'b0, 1'b0, 2'd0, ALU_A_RS1, ALU_B_IMM, 1'b0, 2'd0), cm(1'b0, 1'b1, 1'b0));
    endtask

    task automatic load(input int waits);
        mem_head(OPC_LOAD, waits);
        drive("load_mem", OPC_LOAD, 1'b1, 1'b0, ov(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, ALU_A_RS1, ALU_B_IMM, 1'b0, 2'd0), cm(1'b0, 1'b1, 1'b0));
        drive("load_wb", OPC_LOAD, 1'b1, 1'b0, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, PC_SRC_SEQ, 2'd0, 1'b0, 1'b1, WB_SEL_LOAD), cm(1'b1, 1'b0, 1'b1));
    endtask

    task automatic store(input int waits);
        mem_head(OPC_STORE, waits);
        drive("store_mem", OPC_STORE, 1'b1, 1'b0, ov(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, PC_SRC_SEQ, ALU_A_RS1, ALU_B_IMM, 1'b0, 2'd0), cm(1'b1, 1'b1, 1'b0));
    endtask

    task automatic halting_exec(input logic [6:0] opc);
        fetch(opc, 0);
        drive("halt_exec", opc, 1'b1, 1'b0, 16'h0000, cm(1'b0, 1'b0, 1'b0));
    endtask

    task automatic halt_cycles(input logic [1:0] c, input int n);
        m_halted = 1'b1;
        m_cause  = c;
        for (int i = 0; i < n; i++)
            drive("halt", op, i[0], 1'b0, 16'h0000, cm(1'b0, 1'b0, 1'b0));
    endtask

    // Monitor: compare one queued expectation per cycle, away from the edge
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            mon_act = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_a_sel,
                       alu_b_sel, reg_we, wb_sel, halted, cause};
            n_total++;
            if (((mon_act & mon_e.m) === (mon_e.v & mon_e.m)) && (retired === mon_e.ret))
                n_pass++;
            else
                $display("FAIL %s: got outputs=%h retired=%0d, expected outputs=%h (mask %h) retired=%0d",
                         mon_e.name, mon_act, retired, mon_e.v, mon_e.m, retired === mon_e.ret ? retired : mon_e.ret);
        end
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: simulation did not complete, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "bench timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        // Reset state then ALU class, incl. a 4th-cycle fetch completion
        alu_instr("addi", OPC_OP_IMM, ALU_A_RS1, ALU_B_IMM, 0);
        alu_instr("add", OPC_OP, ALU_A_RS1, ALU_B_RS2, 3);
        alu_instr("lui", OPC_LUI, ALU_A_ZERO, ALU_B_IMM, 0);
        alu_instr("auipc", OPC_AUIPC, ALU_A_PC, ALU_B_IMM, 1);
        load(3);
        store(1);
        store(0);
        branch("beq_taken", 1'b1);
        branch("beq_not_taken", 1'b0);
        jump("jal", OPC_JAL, PC_SRC_REL);
        jump("jalr", OPC_JALR, PC_SRC_JALR);
        fence();
        // Illegal opcode: halt and stay quiet
        halting_exec(7'b0000000);
        halt_cycles(CAUSE_ILLEGAL, 10);
        // SYSTEM
        do_reset();
        fence();
        halting_exec(OPC_SYSTEM);
        halt_cycles(CAUSE_SYSTEM, 3);
        // Fetch timeout after TIMEOUT waiting cycles
        do_reset();
        for (int i = 0; i < 4; i++)
            drive("fetch_to", OPC_OP_IMM, 1'b0, 1'b0, ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0), cm(1'b0, 1'b0, 1'b0));
        halt_cycles(CAUSE_TIMEOUT, 4);
        // Load timeout in MEM: retired frozen at 1
        do_reset();
        alu_instr("addi2", OPC_OP_IMM, ALU_A_RS1, ALU_B_IMM, 0);
        mem_head(OPC_LOAD, 4);
        halt_cycles(CAUSE_TIMEOUT, 4);
        // Reset in the middle of a stalled store
        do_reset();
        mem_head(OPC_STORE, 2);
        do_reset();
        fence();
        alu_instr("addi3", OPC_OP_IMM, ALU_A_RS1, ALU_B_IMM, 0);
        fetch(OPC_FENCE, 0);

        @(negedge clk);
        #1;
        n_total++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
